// File: rtl/debounce_edge.sv
// Synchronizes a raw button input, debounces it with a counter-qualified FSM,
// and emits a registered clean level plus one-cycle rise/fall strobes.
module debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;

  // btn_in is sampled only by the first stage of this chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_LO;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (sync_out) begin
            state <= WAIT_HI;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_HI: begin
          // A glitch wins over the terminal count: the change is rejected.
          if (!sync_out) begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_TERM) begin
            state     <= IDLE_HI;
            cnt       <= '0;
            busy      <= 1'b0;
            btn_level <= 1'b1;
            btn_rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!sync_out) begin
            state <= WAIT_LO;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (sync_out) begin
            state <= IDLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_TERM) begin
            state     <= IDLE_LO;
            cnt       <= '0;
            busy      <= 1'b0;
            btn_level <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
